// File: rtl/mcu_dmaseq.sv
// mcu_dmaseq -- multi-channel DMA address sequencer for the MCU memory-slot
// scheduler. N DMA channels and the DRAM refresh share one bus-slot strobe.
// Every REFRESH_EVERY-th slot is reserved for refresh. All other slots go to
// the pending channels under round-robin arbitration. Each granted slot
// produces one registered word address on the following cycle.
//
// Ports
//   clk         system clock, rising edge
//   res         synchronous reset, active-high
//   slot        one-clk strobe: a bus slot is available this cycle
//   req         per-channel one-clk request pulse
//   cfg_we      config write strobe
//   cfg_ch      target channel (values >= CHANNELS are ignored)
//   cfg_sel     0=start, 1=end, 2=ctrl {repeat, enable}, 3 ignored
//   cfg_data    config write data
//   addr        registered slot address (holds between slots)
//   addr_valid  one-clk pulse: addr is a DMA address
//   addr_ch     channel that owns addr
//   refresh     one-clk pulse: addr is a refresh row address
//   frame_int   per-channel one-clk end-of-frame pulse
//   busy        per-channel enable state
//   overrun     per-channel sticky request overrun, cleared by a ctrl write
module mcu_dmaseq #(
   parameter int CHANNELS      = 2,
   parameter int AW            = 21,
   parameter int REFRESH_EVERY = 4,
   parameter int RW            = 8
) (
   input  logic                clk,
   input  logic                res,
   input  logic                slot,
   input  logic [CHANNELS-1:0] req,
   input  logic                cfg_we,
   input  logic [2:0]          cfg_ch,
   input  logic [1:0]          cfg_sel,
   input  logic [AW-1:0]       cfg_data,
   output logic [AW-1:0]       addr,
   output logic                addr_valid,
   output logic [2:0]          addr_ch,
   output logic                refresh,
   output logic [CHANNELS-1:0] frame_int,
   output logic [CHANNELS-1:0] busy,
   output logic [CHANNELS-1:0] overrun
);

   localparam int SCW = $clog2(REFRESH_EVERY);
   localparam logic [SCW-1:0] SC_LAST = SCW'(REFRESH_EVERY - 1);

   logic [AW-1:0]       start_r [CHANNELS];
   logic [AW-1:0]       end_r   [CHANNELS];
   logic [AW-1:0]       cnt_r   [CHANNELS];
   logic [AW-1:0]       cnt_nxt [CHANNELS];
   logic [CHANNELS-1:0] at_end;
   logic [CHANNELS-1:0] en_r;
   logic [CHANNELS-1:0] rep_r;
   logic [CHANNELS-1:0] pend_r;
   logic [CHANNELS-1:0] ovr_r;

   logic [SCW-1:0]      sc;
   logic [RW-1:0]       row;
   logic [2:0]          last_grant;

   logic [CHANNELS-1:0] wr_start;
   logic [CHANNELS-1:0] wr_end;
   logic [CHANNELS-1:0] wr_ctrl;
   logic [CHANNELS-1:0] dis_now;
   logic [7:0]          elig;
   logic [3:0]          cand;
   logic                grant_any;
   logic [2:0]          grant_ch;
   logic                slot_is_ref;
   logic                do_grant;
   logic [CHANNELS-1:0] gsel;

   // Config decode and per-channel counter lookahead.
   always_comb begin
      wr_start = '0;
      wr_end   = '0;
      wr_ctrl  = '0;
      dis_now  = '0;
      at_end   = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         cnt_nxt[c] = cnt_r[c] + 1'b1;
         at_end[c]  = (cnt_nxt[c] == end_r[c]);
         if (cfg_we && (cfg_ch == 3'(c))) begin
            wr_start[c] = (cfg_sel == 2'd0);
            wr_end[c]   = (cfg_sel == 2'd1);
            wr_ctrl[c]  = (cfg_sel == 2'd2);
         end
         // A disable write kills any grant to that channel in the same cycle.
         dis_now[c] = wr_ctrl[c] && !cfg_data[0];
      end
   end

   // A request in the current cycle makes a channel eligible immediately,
   // so a req and a slot arriving together can be granted at once.
   always_comb begin
      elig = '0;
      elig[CHANNELS-1:0] = en_r & (pend_r | req) & ~dis_now;
   end

   // Round-robin search starting one past the last granted channel.
   always_comb begin
      grant_any = 1'b0;
      grant_ch  = last_grant;
      cand      = '0;
      for (int i = 1; i <= CHANNELS; i++) begin
         cand = {1'b0, last_grant} + 4'(i);
         if (cand >= 4'(CHANNELS)) begin
            cand = cand - 4'(CHANNELS);
         end
         if (!grant_any && elig[cand[2:0]]) begin
            grant_any = 1'b1;
            grant_ch  = cand[2:0];
         end
      end
   end

   assign slot_is_ref = slot && (sc == SC_LAST);
   assign do_grant    = slot && !slot_is_ref && grant_any;

   always_comb begin
      gsel = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         gsel[c] = do_grant && (grant_ch == 3'(c));
      end
   end

   assign busy    = en_r;
   assign overrun = ovr_r;

   always_ff @(posedge clk) begin
      if (res) begin
         addr       <= '0;
         addr_valid <= 1'b0;
         addr_ch    <= '0;
         refresh    <= 1'b0;
         frame_int  <= '0;
         sc         <= '0;
         row        <= '0;
         last_grant <= 3'(CHANNELS - 1);
         en_r       <= '0;
         rep_r      <= '0;
         pend_r     <= '0;
         ovr_r      <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            start_r[c] <= '0;
            end_r[c]   <= '0;
            cnt_r[c]   <= '0;
         end
      end else begin
         addr_valid <= 1'b0;
         refresh    <= 1'b0;
         frame_int  <= '0;

         if (slot) begin
            sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
         end

         if (slot_is_ref) begin
            addr    <= AW'(row);
            row     <= row + 1'b1;
            refresh <= 1'b1;
         end

         if (do_grant) begin
            addr_valid <= 1'b1;
            addr_ch    <= grant_ch;
            last_grant <= grant_ch;
         end

         for (int c = 0; c < CHANNELS; c++) begin
            if (gsel[c]) begin
               addr      <= cnt_r[c];
               // A fresh req arriving with its own grant stays queued.
               pend_r[c] <= req[c];
               if (at_end[c]) begin
                  frame_int[c] <= 1'b1;
                  if (rep_r[c]) begin
                     cnt_r[c] <= start_r[c];
                  end else begin
                     en_r[c]   <= 1'b0;
                     pend_r[c] <= 1'b0;
                  end
               end else begin
                  cnt_r[c] <= cnt_nxt[c];
               end
            end else if (en_r[c] && req[c]) begin
               if (pend_r[c]) begin
                  ovr_r[c] <= 1'b1;
               end
               pend_r[c] <= 1'b1;
            end

            if (wr_start[c]) begin
               start_r[c] <= cfg_data;
            end
            if (wr_end[c]) begin
               end_r[c] <= cfg_data;
            end

            // Ctrl writes land after the grant update so the stored value
            // wins; the grant itself already used the old registers.
            if (wr_ctrl[c]) begin
               rep_r[c] <= cfg_data[1];
               ovr_r[c] <= 1'b0;
               if (cfg_data[0]) begin
                  if (!en_r[c]) begin
                     en_r[c]   <= 1'b1;
                     cnt_r[c]  <= start_r[c];
                     pend_r[c] <= 1'b0;
                  end
               end else begin
                  en_r[c]   <= 1'b0;
                  pend_r[c] <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mcu_dmaseq.sv
// Testbench for mcu_dmaseq: directed scenarios followed by a randomized run.
// Every cycle is checked against a behavioural reference model.
module tb_mcu_dmaseq;

   localparam int CHANNELS      = 2;
   localparam int AW            = 21;
   localparam int REFRESH_EVERY = 4;
   localparam int RW            = 8;
   localparam longint AMASK     = (64'd1 << AW) - 1;

   logic                clk = 1'b0;
   logic                res;
   logic                slot;
   logic [CHANNELS-1:0] req;
   logic                cfg_we;
   logic [2:0]          cfg_ch;
   logic [1:0]          cfg_sel;
   logic [AW-1:0]       cfg_data;
   logic [AW-1:0]       addr;
   logic                addr_valid;
   logic [2:0]          addr_ch;
   logic                refresh;
   logic [CHANNELS-1:0] frame_int;
   logic [CHANNELS-1:0] busy;
   logic [CHANNELS-1:0] overrun;

   mcu_dmaseq #(
      .CHANNELS(CHANNELS), .AW(AW), .REFRESH_EVERY(REFRESH_EVERY), .RW(RW)
   ) dut (
      .clk(clk), .res(res), .slot(slot), .req(req),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
      .addr(addr), .addr_valid(addr_valid), .addr_ch(addr_ch), .refresh(refresh),
      .frame_int(frame_int), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   longint m_start [CHANNELS];
   longint m_end   [CHANNELS];
   longint m_cnt   [CHANNELS];
   bit     m_en    [CHANNELS];
   bit     m_rep   [CHANNELS];
   bit     m_pend  [CHANNELS];
   bit     m_ovr   [CHANNELS];
   int     m_sc, m_row, m_last, m_ch;
   longint m_addr;
   bit     e_valid, e_ref;
   bit     e_frame [CHANNELS];

   // Observation logs for directed scenarios
   longint obs_addr[$];
   int     obs_ch[$];
   int     obs_frames[CHANNELS];
   int     n_ref;

   task automatic model_reset();
      for (int c = 0; c < CHANNELS; c++) begin
         m_start[c] = 0; m_end[c] = 0; m_cnt[c] = 0;
         m_en[c] = 0; m_rep[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
         e_frame[c] = 0;
      end
      m_sc = 0; m_row = 0; m_last = CHANNELS - 1; m_ch = 0; m_addr = 0;
      e_valid = 0; e_ref = 0;
   endtask

   task automatic model_step();
      int  g;
      bit  is_ref;
      bit  old_en;
      bit  wr;
      longint nxt;
      if (res) begin
         model_reset();
         return;
      end
      e_valid = 0;
      e_ref   = 0;
      for (int c = 0; c < CHANNELS; c++) e_frame[c] = 0;
      is_ref = slot && (m_sc == REFRESH_EVERY - 1);
      if (slot) m_sc = (m_sc + 1) % REFRESH_EVERY;
      if (is_ref) begin
         m_addr = m_row;
         m_row  = (m_row + 1) % (1 << RW);
         e_ref  = 1;
      end
      g = -1;
      if (slot && !is_ref) begin
         for (int k = 1; k <= CHANNELS; k++) begin
            int c;
            bit killed;
            c = (m_last + k) % CHANNELS;
            killed = cfg_we && (cfg_ch == c) && (cfg_sel == 2) && !cfg_data[0];
            if (g < 0 && m_en[c] && (m_pend[c] || req[c]) && !killed) g = c;
         end
      end
      if (g >= 0) begin
         e_valid = 1;
         m_addr  = m_cnt[g];
         m_ch    = g;
         m_last  = g;
      end
      for (int c = 0; c < CHANNELS; c++) begin
         old_en = m_en[c];
         wr = cfg_we && (cfg_ch == c);
         if (c == g) begin
            nxt = (m_cnt[c] + 1) & AMASK;
            m_pend[c] = req[c];
            if (nxt == m_end[c]) begin
               e_frame[c] = 1;
               if (m_rep[c]) m_cnt[c] = m_start[c];
               else begin m_en[c] = 0; m_pend[c] = 0; end
            end else begin
               m_cnt[c] = nxt;
            end
         end else if (m_en[c] && req[c]) begin
            if (m_pend[c]) m_ovr[c] = 1;
            m_pend[c] = 1;
         end
         if (wr && cfg_sel == 0) m_start[c] = cfg_data;
         if (wr && cfg_sel == 1) m_end[c] = cfg_data;
         if (wr && cfg_sel == 2) begin
            m_rep[c] = cfg_data[1];
            m_ovr[c] = 0;
            if (cfg_data[0]) begin
               if (!old_en) begin m_en[c] = 1; m_cnt[c] = m_start[c]; m_pend[c] = 0; end
            end else begin
               m_en[c] = 0; m_pend[c] = 0;
            end
         end
      end
   endtask

   task automatic tick();
      logic [CHANNELS-1:0] eb, eo, ef;
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
      for (int c = 0; c < CHANNELS; c++) begin
         eb[c] = m_en[c]; eo[c] = m_ovr[c]; ef[c] = e_frame[c];
      end
      check_val("addr", addr, m_addr);
      check_val("addr_valid", addr_valid, e_valid);
      check_val("addr_ch", addr_ch, m_ch);
      check_val("refresh", refresh, e_ref);
      check_val("frame_int", frame_int, ef);
      check_val("busy", busy, eb);
      check_val("overrun", overrun, eo);
      if (addr_valid === 1'b1) begin
         obs_addr.push_back(addr);
         obs_ch.push_back(addr_ch);
      end
      for (int c = 0; c < CHANNELS; c++) if (frame_int[c] === 1'b1) obs_frames[c]++;
      if (refresh === 1'b1) n_ref++;
   endtask

   task automatic clr();
      res = 0; slot = 0; req = '0; cfg_we = 0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
   endtask

   task automatic clear_obs();
      obs_addr.delete();
      obs_ch.delete();
      for (int c = 0; c < CHANNELS; c++) obs_frames[c] = 0;
      n_ref = 0;
   endtask

   task automatic do_reset();
      clr(); res = 1; tick(); clr();
   endtask

   task automatic cfg(input int ch, input int sel, input longint d);
      clr(); cfg_we = 1; cfg_ch = 3'(ch); cfg_sel = 2'(sel); cfg_data = AW'(d); tick(); clr();
   endtask

   task automatic setup_ch(input int ch, input longint s, input longint e, input int ctrl);
      cfg(ch, 0, s); cfg(ch, 1, e); cfg(ch, 2, ctrl);
   endtask

   task automatic run_slots(input int n, input logic [CHANNELS-1:0] r);
      for (int i = 0; i < n; i++) begin
         clr(); slot = 1; req = r; tick();
      end
      clr();
   endtask

   initial begin
      clr();
      res = 1;
      tick();
      check_val("rst_busy", busy, 0);
      check_val("rst_addr", addr, 0);
      clr();

      // Single frame, repeat off
      do_reset();
      setup_ch(0, 'h100, 'h103, 1);
      clear_obs();
      run_slots(12, 2'b01);
      check_val("s1_ngrant", obs_addr.size(), 3);
      for (int i = 0; i < 3; i++)
         if (i < obs_addr.size()) check_val("s1_seq", obs_addr[i], 'h100 + i);
      check_val("s1_frames", obs_frames[0], 1);
      check_val("s1_busy", busy[0], 0);
      check_val("s1_nref", n_ref, 3);

      // Repeat mode
      do_reset();
      setup_ch(0, 'h100, 'h103, 3);
      clear_obs();
      run_slots(24, 2'b01);
      check_val("s2_ngrant", obs_addr.size(), 18);
      for (int i = 0; i < obs_addr.size(); i++)
         check_val("s2_seq", obs_addr[i], 'h100 + (i % 3));
      check_val("s2_frames", obs_frames[0], 6);
      check_val("s2_busy", busy[0], 1);

      // Round-robin alternation
      do_reset();
      setup_ch(0, 'h100, 'h180, 3);
      setup_ch(1, 'h300, 'h380, 3);
      clear_obs();
      run_slots(12, 2'b11);
      check_val("s3_ngrant", obs_ch.size(), 9);
      for (int i = 0; i < obs_ch.size(); i++)
         check_val("s3_alt", obs_ch[i], i % 2);

      // Overrun
      do_reset();
      setup_ch(1, 'h40, 'h60, 1);
      clear_obs();
      clr(); req = 2'b10; tick();
      clr(); req = 2'b10; tick();
      clr();
      check_val("s4_ovr", overrun[1], 1);
      run_slots(4, 2'b00);
      check_val("s4_ngrant", obs_addr.size(), 1);
      cfg(1, 2, 1);
      check_val("s4_ovr_clr", overrun[1], 0);
      check_val("s4_busy", busy[1], 1);

      // Disable in the same cycle as the grant slot
      do_reset();
      setup_ch(0, 'h100, 'h110, 1);
      clr(); req = 2'b01; tick();
      clr(); slot = 1; cfg_we = 1; cfg_ch = 0; cfg_sel = 2; cfg_data = '0; tick();
      clr();
      check_val("s5_valid", addr_valid, 0);
      check_val("s5_busy", busy[0], 0);

      // Reset mid-frame, then restart
      do_reset();
      setup_ch(0, 'h100, 'h110, 1);
      run_slots(3, 2'b01);
      clr(); res = 1; slot = 1; req = 2'b01; tick(); clr();
      check_val("s6_addr", addr, 0);
      check_val("s6_valid", addr_valid, 0);
      check_val("s6_busy", busy, 0);
      setup_ch(0, 'h100, 'h110, 1);
      clr(); slot = 1; req = 2'b01; tick(); clr();
      check_val("s6_restart", addr, 'h100);

      // Address wrap at 2^AW before reaching end
      do_reset();
      setup_ch(0, 'h1FFFFE, 'h000001, 1);
      clear_obs();
      run_slots(4, 2'b01);
      check_val("s7_ngrant", obs_addr.size(), 3);
      if (obs_addr.size() >= 3) check_val("s7_last", obs_addr[2], 0);
      check_val("s7_frames", obs_frames[0], 1);

      // Randomized run
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         clr();
         slot = ($urandom_range(0, 3) != 0);
         for (int c = 0; c < CHANNELS; c++) req[c] = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 5) == 0) begin
            cfg_we  = 1;
            cfg_ch  = 3'($urandom_range(0, 3));
            cfg_sel = 2'($urandom_range(0, 3));
            if (cfg_sel == 2) cfg_data = AW'($urandom_range(0, 3));
            else if (cfg_sel == 0) cfg_data = AW'('h200 + $urandom_range(0, 7));
            else cfg_data = AW'('h200 + $urandom_range(0, 15));
         end
         if ($urandom_range(0, 599) == 0) res = 1;
         tick();
      end
      clr();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
